bullet_sprite_renderer: RTL and testbench
=========================================

// Module: bullet_sprite_renderer
// PURPOSE
//  Per-pixel renderer for one bullet sprite. Sits between the scan-position
//  generator and the frame compositor. Hit-tests each scan pixel against the
//  bullet box, addresses the 4-bit sprite index ROM, and resolves the index
//  through the 16-entry bullet palette. Emits RGB plus an opaque flag, with a
//  fixed 3-cycle latency.
// PARAMETERS
//  SPR_W    16  sprite width in pixels (power of 2)
//  SPR_H    16  sprite height in pixels
//  ADDR_W    8  ROM address width, = clog2(SPR_W*SPR_H)
//  COORD_W  10  scan/position coordinate width
// PORTS
//  i_clk          in   1        system clock
//  i_rst          in   1        synchronous reset, active-high
//  i_frame_start  in   1        1-cycle pulse at frame start; commits shadow position
//  i_pos_wr       in   1        write shadow position/enable
//  i_pos_x        in   COORD_W  bullet top-left x (shadow)
//  i_pos_y        in   COORD_W  bullet top-left y (shadow)
//  i_enable       in   1        bullet alive (shadow)
//  i_px_valid     in   1        scan pixel valid this cycle
//  i_px_x         in   COORD_W  scan x
//  i_px_y         in   COORD_W  scan y
//  o_rom_addr     out  ADDR_W   sprite ROM address, registered
//  i_rom_idx      in   4        ROM data, 1-cycle synchronous read of o_rom_addr
//  i_color_map    in   24x16    palette array [0:15]; entry 0 is transparent
//  o_valid        out  1        output pixel valid
//  o_rgb          out  24       pixel colour; 0 when not opaque
//  o_opaque       out  1        1 = compositor draws o_rgb over background
//  o_px_count     out  16       opaque pixels drawn in the previous frame
// BEHAVIOUR
//  Reset: all outputs 0. Shadow and active pos = 0. Shadow and active enable = 0.
//   Pipeline valids cleared. Running count = 0. Reset mid-frame flushes
//   in-flight pixels; no o_valid until 3 cycles after the next i_px_valid.
//  Position:
//   - i_pos_wr loads the shadow registers.
//   - i_frame_start copies shadow to active.
//   - If both occur in the same cycle, active takes the new input values
//     directly (write-through).
//   - Active values never change mid-frame.
//  Pipeline, with pixel presented at cycle N:
//   S1 (edge N+1):
//    - dx = {1'b0,px_x} - {1'b0,pos_x}; dy likewise (COORD_W+1 bits, two's complement).
//    - hit = en & px_valid & 0<=dx<SPR_W & 0<=dy<SPR_H.
//    - o_rom_addr = dy*SPR_W + dx when hit, else held.
//    - Sprites past the right/bottom edge clip naturally; dx is never wrapped.
//   S2 (edge N+2): hit and valid delayed one stage; i_rom_idx valid in this cycle.
//   S3 (edge N+3):
//    - o_valid = valid.
//    - o_opaque = hit & (idx != 0).
//    - o_rgb = o_opaque ? i_color_map[idx] : 24'h0.
//    - Index 15 (black) is opaque.
//  Pixel count:
//   - The 16-bit running count increments on each S3 cycle with o_opaque=1,
//     saturating at 16'hFFFF.
//   - On i_frame_start, o_px_count <= running value and the running count
//     restarts. It loads 1 if an opaque pixel lands that same cycle, else 0.
//  Invalid pixels:
//   - i_px_valid=0 produces o_valid=0 and o_opaque=0 three cycles later.
//   - o_rgb is 0 in those cycles.
//  Throughput: 1 pixel/cycle, no stalls, no backpressure.
// TESTING
//  1 Reset: pos (100,50) shadow + enable, frame_start, pixel (100,50) -> at N+3
//    o_valid=1, o_rom_addr was 0, o_rgb=map[idx].
//  2 Transparency: ROM idx 0 at hit pixel -> o_opaque=0, o_rgb=0. Idx 15 ->
//    o_opaque=1, o_rgb=24'h000000.
//  3 Bounds at pos (100,50): (99,50) and (116,50) miss; (115,65) hits with
//    addr 255; (100,66) misses.
//  4 Edge clip: pos (1020,0), scan x 1020..1023 -> addr 0..3 hit; x=0..3 on
//    the next line miss.
//  5 Shadow timing: i_pos_wr to (200,50) mid-frame -> rendering stays at
//    (100,50) until frame_start. Coincident pos_wr+frame_start -> new pos active.
//  6 Count: 17 opaque pixels in a frame, then frame_start -> o_px_count=17. A
//    disabled bullet's frame -> next o_px_count=0. Reset mid-stream -> o_valid=0
//    for 3 cycles.

Source files
------------

// File: rtl/bullet_sprite_renderer_if.sv
// Pixel-stream and sprite-ROM bundle between the scan generator, the bullet
// renderer and the frame compositor.
interface bullet_sprite_renderer_if #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 10
);
    logic               i_frame_start;
    logic               i_pos_wr;
    logic [COORD_W-1:0] i_pos_x;
    logic [COORD_W-1:0] i_pos_y;
    logic               i_enable;
    logic               i_px_valid;
    logic [COORD_W-1:0] i_px_x;
    logic [COORD_W-1:0] i_px_y;
    logic [ADDR_W-1:0]  o_rom_addr;
    logic [3:0]         i_rom_idx;
    logic [23:0]        i_color_map [0:15];
    logic               o_valid;
    logic [23:0]        o_rgb;
    logic               o_opaque;
    logic [15:0]        o_px_count;

    // Valid-only stream: a pixel transfers on every cycle i_px_valid is high,
    // and o_valid follows exactly 3 cycles later. There is no ready/stall path.
    modport slave (
        input  i_frame_start, i_pos_wr, i_pos_x, i_pos_y, i_enable,
        input  i_px_valid, i_px_x, i_px_y, i_rom_idx, i_color_map,
        output o_rom_addr, o_valid, o_rgb, o_opaque, o_px_count
    );

    modport master (
        output i_frame_start, i_pos_wr, i_pos_x, i_pos_y, i_enable,
        output i_px_valid, i_px_x, i_px_y, i_rom_idx, i_color_map,
        input  o_rom_addr, o_valid, o_rgb, o_opaque, o_px_count
    );
endinterface

// File: rtl/bullet_sprite_renderer.sv
// Three-stage bullet sprite renderer: box hit-test and ROM addressing, ROM
// read wait, palette lookup; plus a per-frame opaque pixel counter.
module bullet_sprite_renderer #(
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 10
) (
    input logic i_clk,
    input logic i_rst,
    bullet_sprite_renderer_if.slave bus
);
    localparam int DW = COORD_W + 1;

    logic [COORD_W-1:0] sh_x, sh_y, act_x, act_y;
    logic               sh_en, act_en;
    logic               s1_valid, s1_hit, s2_valid, s2_hit;
    logic [15:0]        run_count;

    logic [DW-1:0]      dx, dy;
    logic               hit;
    logic [ADDR_W-1:0]  addr_next;
    logic               opq_next;
    logic [23:0]        rgb_next;

    // Extra sign bit keeps pixels left of / above the box negative instead of
    // wrapping them into range.
    assign dx = {1'b0, bus.i_px_x} - {1'b0, act_x};
    assign dy = {1'b0, bus.i_px_y} - {1'b0, act_y};
    assign hit = act_en & bus.i_px_valid &
                 ~dx[DW-1] & (dx < DW'(SPR_W)) &
                 ~dy[DW-1] & (dy < DW'(SPR_H));
    assign addr_next = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);

    assign opq_next = s2_hit & (bus.i_rom_idx != 4'd0);
    assign rgb_next = opq_next ? bus.i_color_map[bus.i_rom_idx] : 24'h0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_x           <= '0;
            sh_y           <= '0;
            sh_en          <= 1'b0;
            act_x          <= '0;
            act_y          <= '0;
            act_en         <= 1'b0;
            s1_valid       <= 1'b0;
            s1_hit         <= 1'b0;
            s2_valid       <= 1'b0;
            s2_hit         <= 1'b0;
            run_count      <= '0;
            bus.o_rom_addr <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_opaque   <= 1'b0;
            bus.o_rgb      <= '0;
            bus.o_px_count <= '0;
        end else begin
            if (bus.i_pos_wr) begin
                sh_x  <= bus.i_pos_x;
                sh_y  <= bus.i_pos_y;
                sh_en <= bus.i_enable;
            end
            // Active position only moves at frame boundaries; a coincident
            // write goes straight through to the active copy.
            if (bus.i_frame_start) begin
                act_x  <= bus.i_pos_wr ? bus.i_pos_x  : sh_x;
                act_y  <= bus.i_pos_wr ? bus.i_pos_y  : sh_y;
                act_en <= bus.i_pos_wr ? bus.i_enable : sh_en;
            end

            s1_valid <= bus.i_px_valid;
            s1_hit   <= hit;
            if (hit) begin
                bus.o_rom_addr <= addr_next;
            end

            s2_valid <= s1_valid;
            s2_hit   <= s1_hit;

            bus.o_valid  <= s2_valid;
            bus.o_opaque <= opq_next;
            bus.o_rgb    <= rgb_next;

            // A pixel landing on the frame_start edge belongs to the new frame.
            if (bus.i_frame_start) begin
                bus.o_px_count <= run_count;
                run_count      <= opq_next ? 16'd1 : 16'd0;
            end else if (opq_next && run_count != 16'hFFFF) begin
                run_count <= run_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_bullet_sprite_renderer.sv
// Self-checking bench for bullet_sprite_renderer: directed scenarios plus a
// randomized run, scored against a pixel-level reference model.
module tb_bullet_sprite_renderer;
  localparam int CW = 10;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bullet_sprite_renderer_if #(.ADDR_W(AW), .COORD_W(CW)) bus ();

  bullet_sprite_renderer #(.SPR_W(16), .SPR_H(16), .ADDR_W(AW), .COORD_W(CW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  // Sprite ROM with 1-cycle synchronous read, and palette
  logic [3:0]  rom  [0:255];
  logic [23:0] cmap [0:15];
  always @(posedge clk) bus.i_rom_idx <= rom[bus.o_rom_addr];
  assign bus.i_color_map = cmap;

  // ---------------- reference model / scoreboard ----------------
  // entry = {valid, opaque, rgb} expected 3 cycles after the pixel
  logic [25:0] exp_q[$];
  int sh_x, sh_y, act_x, act_y;
  bit sh_en, act_en;
  logic [7:0] m_addr;
  int m_run, m_cnt;
  bit armed;
  int total, bad;

  task automatic step(input bit r, input bit fs, input bit pw, input bit en,
                      input int wx, input int wy, input bit pv, input int px, input int py);
    logic [25:0] e;
    logic [3:0] idx;
    bit h, opq, land;
    int dx, dy;
    @(negedge clk);
    if (armed) begin
      if (exp_q.size() >= 3) begin
        e = exp_q.pop_front();
        total++;
        if ({bus.o_valid, bus.o_opaque, bus.o_rgb} !== e) begin
          bad++;
          $display("FAIL pixel_out t=%0t got v=%b o=%b rgb=%h want v=%b o=%b rgb=%h",
                   $time, bus.o_valid, bus.o_opaque, bus.o_rgb, e[25], e[24], e[23:0]);
        end
      end
      total++;
      if (bus.o_rom_addr !== m_addr) begin
        bad++;
        $display("FAIL rom_addr t=%0t got %0d want %0d", $time, bus.o_rom_addr, m_addr);
      end
      total++;
      if (bus.o_px_count !== 16'(m_cnt)) begin
        bad++;
        $display("FAIL px_count t=%0t got %0d want %0d", $time, bus.o_px_count, m_cnt);
      end
    end
    rst = r;
    bus.i_frame_start = fs;
    bus.i_pos_wr = pw;
    bus.i_enable = en;
    bus.i_pos_x = CW'(wx);
    bus.i_pos_y = CW'(wy);
    bus.i_px_valid = pv;
    bus.i_px_x = CW'(px);
    bus.i_px_y = CW'(py);
    if (r) begin
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
      sh_x = 0; sh_y = 0; sh_en = 0;
      act_x = 0; act_y = 0; act_en = 0;
      m_addr = '0; m_run = 0; m_cnt = 0;
      armed = 1;
    end else begin
      dx = px - act_x;
      dy = py - act_y;
      h = act_en && pv && dx >= 0 && dx < 16 && dy >= 0 && dy < 16;
      idx = 4'd0;
      if (h) begin
        m_addr = 8'(dy * 16 + dx);
        idx = rom[m_addr];
      end
      opq = h && (idx != 4'd0);
      land = (exp_q.size() > 0) ? exp_q[0][24] : 1'b0;
      if (fs) begin
        m_cnt = m_run;
        m_run = land ? 1 : 0;
      end else if (land && m_run < 65535) begin
        m_run++;
      end
      if (fs) begin
        if (pw) begin act_x = wx; act_y = wy; act_en = en; end
        else begin act_x = sh_x; act_y = sh_y; act_en = sh_en; end
      end
      if (pw) begin sh_x = wx; sh_y = wy; sh_en = en; end
      exp_q.push_back({pv, opq, opq ? cmap[idx] : 24'h0});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic pix(input int x, input int y);
    step(0, 0, 0, 0, 0, 0, 1, x, y);
  endtask
  task automatic wr(input int x, input int y, input bit en);
    step(0, 0, 1, en, x, y, 0, 0, 0);
  endtask
  task automatic frame();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_opaque !== 1'b0 || bus.o_rgb !== 24'h0 ||
        bus.o_rom_addr !== 8'd0 || bus.o_px_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs v=%b o=%b rgb=%h addr=%0d cnt=%0d want all 0",
               bus.o_valid, bus.o_opaque, bus.o_rgb, bus.o_rom_addr, bus.o_px_count);
    end
    wr(100, 50, 1);
    frame();
    pix(100, 50);
    idle(3);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_rgb !== cmap[5]) begin
      bad++;
      $display("FAIL first_pixel v=%b rgb=%h want v=1 rgb=%h", bus.o_valid, bus.o_rgb, cmap[5]);
    end
  endtask

  task automatic test_transparency();
    pix(101, 50);
    idle(3);
    total++;
    if (bus.o_opaque !== 1'b0 || bus.o_rgb !== 24'h0) begin
      bad++;
      $display("FAIL idx0_transparent o=%b rgb=%h want o=0 rgb=0", bus.o_opaque, bus.o_rgb);
    end
    pix(102, 50);
    idle(3);
    total++;
    if (bus.o_opaque !== 1'b1 || bus.o_rgb !== 24'h0) begin
      bad++;
      $display("FAIL idx15_black o=%b rgb=%h want o=1 rgb=0", bus.o_opaque, bus.o_rgb);
    end
  endtask

  task automatic test_bounds();
    pix(99, 50);
    pix(116, 50);
    pix(115, 65);
    pix(100, 66);
    pix(100, 49);
    idle(3);
    total++;
    if (bus.o_rom_addr !== 8'd255) begin
      bad++;
      $display("FAIL bounds_addr got %0d want 255", bus.o_rom_addr);
    end
  endtask

  task automatic test_edge_clip();
    wr(1020, 0, 1);
    frame();
    for (int x = 1020; x < 1024; x++) pix(x, 0);
    for (int x = 0; x < 4; x++) pix(x, 1);
    idle(3);
    total++;
    if (bus.o_rom_addr !== 8'd3) begin
      bad++;
      $display("FAIL clip_addr got %0d want 3", bus.o_rom_addr);
    end
  endtask

  task automatic test_shadow();
    wr(100, 50, 1);
    frame();
    wr(200, 50, 1);
    pix(100, 50);
    pix(200, 50);
    idle(3);
    total++;
    if (bus.o_rom_addr !== 8'd0) begin
      bad++;
      $display("FAIL shadow_hold_addr got %0d want 0", bus.o_rom_addr);
    end
    frame();
    pix(200, 51);
    idle(1);
    total++;
    if (bus.o_rom_addr !== 8'd16) begin
      bad++;
      $display("FAIL shadow_commit_addr got %0d want 16", bus.o_rom_addr);
    end
    step(0, 1, 1, 1, 300, 60, 0, 0, 0);
    pix(301, 60);
    idle(1);
    total++;
    if (bus.o_rom_addr !== 8'd1) begin
      bad++;
      $display("FAIL write_through_addr got %0d want 1", bus.o_rom_addr);
    end
    idle(3);
  endtask

  task automatic test_count();
    wr(100, 50, 1);
    frame();
    for (int i = 0; i < 17; i++) pix(100 + i % 16, 50 + i / 16);
    idle(3);
    frame();
    idle(1);
    total++;
    if (bus.o_px_count !== 16'd17) begin
      bad++;
      $display("FAIL count_17 got %0d want 17", bus.o_px_count);
    end
    step(0, 1, 1, 0, 100, 50, 0, 0, 0);
    for (int i = 0; i < 8; i++) pix(100 + i, 50);
    idle(3);
    frame();
    idle(1);
    total++;
    if (bus.o_px_count !== 16'd0) begin
      bad++;
      $display("FAIL count_disabled got %0d want 0", bus.o_px_count);
    end
    step(0, 1, 1, 1, 100, 50, 0, 0, 0);
    for (int i = 0; i < 4; i++) pix(100 + i, 50);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      total++;
      if (bus.o_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_flush cycle=%0d got v=%b want 0", i, bus.o_valid);
      end
    end
  endtask

  task automatic test_random();
    int x, y;
    wr(500, 300, 1);
    frame();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)
        step(0, 1, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 0, 0);
      else if ($urandom_range(0, 29) == 0)
        wr($urandom_range(990, 1023), $urandom_range(0, 1023), $urandom_range(0, 3) != 0);
      else begin
        x = (act_x + $urandom_range(0, 21) + 1022) % 1024;
        y = (act_y + $urandom_range(0, 19) + 1022) % 1024;
        step(0, 0, 0, 0, 0, 0, $urandom_range(0, 4) != 0, x, y);
      end
    end
    idle(4);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0; bad = 0; armed = 0;
    rst = 1'b1;
    bus.i_frame_start = 0; bus.i_pos_wr = 0; bus.i_enable = 0;
    bus.i_pos_x = '0; bus.i_pos_y = '0;
    bus.i_px_valid = 0; bus.i_px_x = '0; bus.i_px_y = '0;
    for (int i = 0; i < 16; i++) cmap[i] = 24'($urandom_range(1, 24'hFFFFFF));
    cmap[15] = 24'h000000;
    for (int i = 0; i < 256; i++) rom[i] = 4'($urandom_range(1, 15));
    rom[0] = 4'd5;
    rom[1] = 4'd0;
    rom[2] = 4'd15;
    test_reset();
    test_transparency();
    test_bounds();
    test_edge_clip();
    test_shadow();
    rom[1] = 4'd7;
    test_count();
    idle(3);
    for (int i = 0; i < 256; i++) rom[i] = 4'($urandom_range(0, 15));
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
